// File: rtl/checksum_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : checksum_pipeline
// Description : Two-stage valid/ready pipeline that computes a CSUM_W-bit
//               checksum over DATA_W data bits (XOR fold or inverted
//               ones-complement fold), compares it against the received
//               checksum and forwards {data, computed checksum}.
//               Optional bad-checksum counter: define CHECKSUM_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module checksum_pipeline #(
   parameter int DATA_W = 56,
   parameter int CSUM_W = 8,
   parameter int MODE   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W+CSUM_W-1:0] in_flit,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W+CSUM_W-1:0] out_flit,
   output logic                     out_csum_ok
`ifdef CHECKSUM_ERR_CNT_EN
   ,
   input  logic                     err_clr,
   output logic [15:0]              err_count
`endif
);

   localparam int c_num_chunks = DATA_W / CSUM_W;

   logic [DATA_W-1:0] w_data;
   logic [CSUM_W-1:0] w_rx_csum;
   logic [CSUM_W-1:0] w_csum;
   logic              w_s1_load_en;
   logic              w_s2_load_en;

   logic              r_s1_valid;
   logic [DATA_W-1:0] r_s1_data;
   logic [CSUM_W-1:0] r_s1_rx_csum;
   logic [CSUM_W-1:0] r_s1_csum;
   logic              r_s2_valid;
   logic [DATA_W+CSUM_W-1:0] r_s2_flit;
   logic              r_s2_ok;

   assign w_data    = in_flit[DATA_W+CSUM_W-1:CSUM_W];
   assign w_rx_csum = in_flit[CSUM_W-1:0];

   generate
      if (MODE == 0) begin : g_xor_fold
         // XOR of every CSUM_W-bit chunk of the data
         always_comb begin
            w_csum = '0;
            for (int i = 0; i < c_num_chunks; i++) begin
               w_csum = w_csum ^ w_data[i*CSUM_W +: CSUM_W];
            end
         end
      end else begin : g_ones_fold
         // Wide enough to hold the raw sum of all chunks without overflow
         localparam int c_sum_w = CSUM_W + $clog2(c_num_chunks) + 1;
         logic [c_sum_w-1:0] w_sum;
         // Raw sum, then end-around carry folds until no carry remains, then invert
         always_comb begin
            w_sum = '0;
            for (int i = 0; i < c_num_chunks; i++) begin
               w_sum = w_sum + c_sum_w'(w_data[i*CSUM_W +: CSUM_W]);
            end
            // Each fold strictly shrinks the value; c_sum_w folds always suffice
            for (int k = 0; k < c_sum_w; k++) begin
               w_sum = c_sum_w'(w_sum[CSUM_W-1:0]) + (w_sum >> CSUM_W);
            end
            w_csum = ~w_sum[CSUM_W-1:0];
         end
      end
   endgenerate

   // Stage 2 frees up when empty or draining; stage 1 when empty or it can advance
   assign w_s2_load_en = !r_s2_valid || out_ready;
   assign w_s1_load_en = !r_s1_valid || w_s2_load_en;
   assign in_ready     = w_s1_load_en;

   // Stage 1: capture data, received checksum and computed checksum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid   <= 1'b0;
         r_s1_data    <= '0;
         r_s1_rx_csum <= '0;
         r_s1_csum    <= '0;
      end else if (w_s1_load_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_data    <= w_data;
            r_s1_rx_csum <= w_rx_csum;
            r_s1_csum    <= w_csum;
         end
      end
   end

   // Stage 2: output flit and checksum comparison, held while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_flit  <= '0;
         r_s2_ok    <= 1'b0;
      end else if (w_s2_load_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_flit <= {r_s1_data, r_s1_csum};
            r_s2_ok   <= (r_s1_rx_csum == r_s1_csum);
         end
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_flit    = r_s2_flit;
   assign out_csum_ok = r_s2_ok;

`ifdef CHECKSUM_ERR_CNT_EN
   logic [15:0] r_err_count;

   // Saturating count of bad flits leaving the block; clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_count <= '0;
      end else if (err_clr) begin
         r_err_count <= '0;
      end else if (r_s2_valid && out_ready && !r_s2_ok && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: doc/checksum_pipeline.md
CHECKSUM_PIPELINE -- requirements
Module: checksum_pipeline

Interface
REQ-001 SHALL have parameter DATA_W, default 56: header+payload width in bits; must be a multiple of CSUM_W and at least 2*CSUM_W.
REQ-002 SHALL have parameter CSUM_W, default 8: checksum width in bits.
REQ-003 SHALL have parameter MODE, default 0: 0 = XOR fold; 1 = inverted ones-complement sum fold.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input flit present.
REQ-007 SHALL have port in_ready  output  1  block accepts the input flit this cycle.
REQ-008 SHALL have port in_flit  input  DATA_W+CSUM_W  {data, received checksum}, with the checksum in the LSBs.
REQ-009 SHALL have port out_valid  output  1  output flit present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output flit.
REQ-011 SHALL have port out_flit  output  DATA_W+CSUM_W  {data, computed checksum}.
REQ-012 SHALL have port out_csum_ok  output  1  received checksum equals the computed checksum; qualified by out_valid.
REQ-013 SHALL have port err_clr  input  1  synchronous clear of err_count; present only when the configuration macro is defined.
REQ-014 SHALL have port err_count  output  16  count of bad-checksum flits; present only when the configuration macro is defined.

Function
REQ-015 SHALL split data into DATA_W/CSUM_W chunks of CSUM_W bits each.
REQ-016 SHALL, in MODE 0, compute the checksum as the XOR of all chunks.
REQ-017 SHALL, in MODE 1, sum all chunks with end-around carry, folded until no carry remains, and output the bitwise inverse of that sum.
REQ-018 SHALL be a 2-stage pipeline:
- Stage 1 registers the data, the received checksum and the computed checksum.
- Stage 2 registers out_flit and out_csum_ok.
REQ-019 SHALL transfer a flit on any cycle where valid && ready are both high, on either port.
REQ-020 SHALL have latency of exactly 2 cycles from input transfer to out_valid when no stall occurs.
REQ-021 SHALL sustain a throughput of 1 flit per cycle while out_ready is held high.
REQ-022 SHALL treat stage 2 as able to load when it is empty or out_ready=1.
REQ-023 SHALL treat stage 1 as able to load when it is empty or stage 2 is able to load.
REQ-024 SHALL drive in_ready as the stage-1 load condition, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-025 SHALL, while out_valid=1 and out_ready=0, hold out_flit and out_csum_ok stable and neither drop nor duplicate any flit.
REQ-026 SHALL reflect a full stall (both stages valid, out_ready=0) as in_ready=0 in the same cycle.
REQ-027 SHALL, when an output transfer and an input transfer occur in the same cycle, advance both stages with no bubble inserted.
REQ-028 SHALL treat out_flit and out_csum_ok contents as don't-care while out_valid=0.

Reset
REQ-029 SHALL, on rst assertion, immediately clear both stage valid bits, out_valid, out_csum_ok, out_flit and err_count to 0, independent of clk.
REQ-030 SHALL discard any in-flight flits on reset mid-operation; no flit is emitted after reset is released.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-032 SHALL, with macro CHECKSUM_ERR_CNT_EN defined, provide err_clr and err_count.
- err_count increments by 1 on each output transfer with out_csum_ok=0.
- err_count saturates at 0xFFFF.
- err_clr has priority over a simultaneous increment and yields 0.
REQ-033 SHALL, with CHECKSUM_ERR_CNT_EN undefined, omit err_clr, err_count and the counter logic; datapath behaviour is otherwise identical.

Verification
REQ-034 SHALL cover: DATA_W=16, CSUM_W=8, MODE=0, in_flit=0x1234_26 with out_ready=1 -> 2 cycles later out_valid=1, out_flit=0x1234_26, out_csum_ok=1.
REQ-035 SHALL cover: MODE=1, in_flit=0xFF01_00 -> computed checksum 0xFE, out_flit=0xFF01_FE, out_csum_ok=0.
REQ-036 SHALL cover: 5 back-to-back flits, out_ready low for cycles 3-6 -> in_ready drops once both stages are full; all 5 flits emitted in order; no loss or duplication.
REQ-037 SHALL cover: rst asserted while 2 flits are in flight -> out_valid=0 at once; no output after release; in_ready=1 on the first post-reset cycle.
REQ-038 SHALL cover, with CHECKSUM_ERR_CNT_EN defined: err_count preloaded to 0xFFFE, then 3 bad flits -> err_count=0xFFFF; then err_clr together with a bad transfer -> err_count=0.
